// File: rtl/mips_ctrl_pkg.sv
// Package: mips_ctrl_pkg
// Shared definitions for the multicycle MIPS main control FSM:
//   - state_t    : 4-bit state encoding (codes 12-15 unused)
//   - OP_*       : opcode field values recognised in DECODE/MEMADR
//   - alu_op_t   : ALU operation select encodings
//   - src_b_t    : ALU operand B mux encodings
//   - pc_src_t   : PC source mux encodings
//   - ctrl_t     : full Moore control word produced by mips_ctrl_outdec
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_ADDI  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_B        = 2'b00,
        SRCB_FOUR     = 2'b01,
        SRCB_SEXT     = 2'b10,
        SRCB_SEXT_SH2 = 2'b11
    } src_b_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_t;

    typedef struct packed {
        logic    pc_write;
        logic    pc_write_cond;
        logic    iord;
        logic    mem_read;
        logic    mem_write;
        logic    ir_write;
        logic    mem_to_reg;
        logic    reg_dst;
        logic    reg_write;
        logic    alu_src_a;
        src_b_t  alu_src_b;
        alu_op_t alu_op;
        pc_src_t pc_src;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Module: mips_ctrl_outdec
// Purely combinational Moore output decode: registered state -> control word.
// Ports:
//   state  in   state_t  current FSM state
//   ctrl   out  ctrl_t   datapath selects and write enables for that state
// Unused state codes decode to an all-zero control word.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        // NOTE: every field gets a default before the case so no path can
        // leave a field unassigned and infer a latch.
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_write  = 1'b1;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_SEXT_SH2;
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
                ctrl.alu_op    = ALU_ADDI;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Module: mips_multicycle_ctrl
// Main control FSM for the multicycle MIPS datapath. Holds the state register
// and next-state logic; the Moore output decode lives in mips_ctrl_outdec.
// Ports:
//   clk, reset (sync, active-high, forces FETCH)
//   opcode        instr[31:26], sampled only in DECODE and MEMADR
//   mem_ready     memory done (only with MIPS_CTRL_MEM_WAIT_EN)
//   pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
//   alu_op[1:0], pc_src[1:0]   datapath controls
//   illegal_op    one-cycle pulse in DECODE on an unknown opcode
//   state_o       current state encoding (debug)
// Configuration macro: MIPS_CTRL_MEM_WAIT_EN -- FETCH/MEMRD/MEMWR hold until
// mem_ready=1; ir_write and pc_write in FETCH only fire on the ready cycle.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           pc_write,
    output logic           pc_write_cond,
    output logic           iord,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_write,
    output logic           mem_to_reg,
    output logic           reg_dst,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic [1:0]     pc_src,
    output logic           illegal_op,
    output logic [STW-1:0] state_o
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    logic   known_op;
    logic   mem_done;

`ifdef MIPS_CTRL_MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done         = 1'b1;
`endif

    always_ff @(posedge clk) begin
        // NOTE: state is updated with a non-blocking assignment so every
        // reader in this time step sees the pre-edge value.
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = S_FETCH;
        known_op = 1'b1;
        case (state_q)
            S_FETCH: state_d = mem_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OPW'(OP_LW) || opcode == OPW'(OP_SW)) state_d = S_MEMADR;
                else if (opcode == OPW'(OP_R))    state_d = S_EXEC;
                else if (opcode == OPW'(OP_BEQ))  state_d = S_BRANCH;
                else if (opcode == OPW'(OP_J))    state_d = S_JUMP;
                else if (opcode == OPW'(OP_ADDI)) state_d = S_ADDIEX;
                else                              known_op = 1'b0;
            end
            // Opcode is re-examined here; anything but LW/SW abandons the access.
            S_MEMADR: begin
                if (opcode == OPW'(OP_LW))      state_d = S_MEMRD;
                else if (opcode == OPW'(OP_SW)) state_d = S_MEMWR;
            end
            S_MEMRD:  state_d = mem_done ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_done ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state (state_q),
        .ctrl  (ctrl)
    );

    // Fetch side effects (IR load, PC+4) wait for the read to complete;
    // the PC load in JUMP is not tied to memory.
    assign ir_write      = ctrl.ir_write & mem_done;
    assign pc_write      = ctrl.pc_write & (mem_done | (state_q != S_FETCH));
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_src        = ctrl.pc_src;
    assign illegal_op    = (state_q == S_DECODE) & ~known_op;
    assign state_o       = STW'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench: tb_mips_multicycle_ctrl
// Table-driven check of the multicycle MIPS control FSM: each vector drives
// reset/opcode for one cycle and states the expected state and control word,
// taken from the state/output table. Hand-written sequences cover mem_ready
// behaviour in both builds (macro MIPS_CTRL_MEM_WAIT_EN).
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state_o;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.OPW(6), .STW(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src),
        .illegal_op    (illegal_op),
        .state_o       (state_o)
    );

    typedef struct {
        logic       rst;
        logic [5:0] opc;
        int         st;
        bit         ill;
    } vec_t;

    vec_t vecs[$];

    // Word layout: {pc_write, pc_write_cond, iord, mem_read, mem_write,
    // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
    // alu_op[1:0], pc_src[1:0], illegal_op}
    function automatic logic [16:0] spec_word(int st, bit ill);
        logic pw = 0, pwc = 0, io = 0, mr = 0, mw = 0, irw = 0;
        logic m2r = 0, rd = 0, rw = 0, sa = 0;
        logic [1:0] sb = 2'b00, op = 2'b00, ps = 2'b00;
        case (st)
            0:  begin mr = 1; irw = 1; sb = 2'b01; pw = 1; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mr = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; io = 1; end
            6:  begin sa = 1; op = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin sa = 1; sb = 2'b10; op = 2'b11; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps, ill};
    endfunction

    function automatic logic [16:0] dut_word();
        return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_src, illegal_op};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, sample 1 ns later.
    task automatic step(input logic rst, input logic [5:0] opc, input logic rdy);
        @(negedge clk);
        reset     = rst;
        opcode    = opc;
        mem_ready = rdy;
        #1;
    endtask

    task automatic add(input logic rst, input logic [5:0] opc, input int st, input bit ill);
        vecs.push_back('{rst, opc, st, ill});
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = R;
        mem_ready = 1'b1;

        // LW: 0,1,2,3,4
        add(0, LW, 0, 0);  add(0, LW, 1, 0);  add(0, LW, 2, 0);
        add(0, LW, 3, 0);  add(0, LW, 4, 0);
        // R-type, opcode changed in EXEC must be ignored: 0,1,6,7
        add(0, R, 0, 0);   add(0, R, 1, 0);   add(0, J, 6, 0);   add(0, J, 7, 0);
        // BEQ: 0,1,8
        add(0, BEQ, 0, 0); add(0, BEQ, 1, 0); add(0, BEQ, 8, 0);
        // J: 0,1,9
        add(0, J, 0, 0);   add(0, J, 1, 0);   add(0, J, 9, 0);
        // ADDI: 0,1,10,11 (opcode changed in ADDIEX/ADDIWB)
        add(0, ADDI, 0, 0); add(0, ADDI, 1, 0); add(0, ADDI, 10, 0); add(0, SW, 11, 0);
        // SW: 0,1,2,5
        add(0, SW, 0, 0);  add(0, SW, 1, 0);  add(0, SW, 2, 0);  add(0, SW, 5, 0);
        // illegal opcode: pulse in DECODE only, then FETCH
        add(0, BAD, 0, 0); add(0, BAD, 1, 1); add(0, LW, 0, 0);
        // reset in MEMRD: back to FETCH, MEMWB never reached
        add(0, LW, 1, 0);  add(0, LW, 2, 0);  add(1, LW, 3, 0);
        add(0, LW, 0, 0);  add(0, LW, 1, 0);

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].opc, 1'b1);
            check($sformatf("vec%0d state", i), 32'(state_o), 32'(vecs[i].st));
            check($sformatf("vec%0d ctrl", i), 32'(dut_word()),
                  32'(spec_word(vecs[i].st, vecs[i].ill)));
        end

        step(1'b1, SW, 1'b0);
`ifdef MIPS_CTRL_MEM_WAIT_EN
        // FETCH held while memory not ready: strobe up, IR/PC loads suppressed.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, SW, 1'b0);
            check($sformatf("wait fetch%0d state", k), 32'(state_o), 32'd0);
            check($sformatf("wait fetch%0d mem_read", k), 32'(mem_read), 32'd1);
            check($sformatf("wait fetch%0d ir_write", k), 32'(ir_write), 32'd0);
            check($sformatf("wait fetch%0d pc_write", k), 32'(pc_write), 32'd0);
        end
        step(1'b0, SW, 1'b1);
        check("wait fetch ready ir_write", 32'(ir_write), 32'd1);
        check("wait fetch ready pc_write", 32'(pc_write), 32'd1);
        step(1'b0, SW, 1'b1);
        check("wait decode state", 32'(state_o), 32'd1);
        step(1'b0, SW, 1'b1);
        check("wait memadr state", 32'(state_o), 32'd2);
        // MEMWR: three not-ready cycles plus the ready one -> 4 cycles of mem_write.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, SW, k == 3);
            check($sformatf("wait memwr%0d state", k), 32'(state_o), 32'd5);
            check($sformatf("wait memwr%0d mem_write", k), 32'(mem_write), 32'd1);
        end
        step(1'b0, SW, 1'b1);
        check("wait after memwr state", 32'(state_o), 32'd0);
        check("wait after memwr mem_write", 32'(mem_write), 32'd0);
`else
        // mem_ready is ignored: every memory state lasts one cycle.
        step(1'b0, LW, 1'b0);
        check("noready fetch state", 32'(state_o), 32'd0);
        check("noready fetch ir_write", 32'(ir_write), 32'd1);
        check("noready fetch pc_write", 32'(pc_write), 32'd1);
        step(1'b0, LW, 1'b0);
        check("noready decode state", 32'(state_o), 32'd1);
        step(1'b0, LW, 1'b0);
        check("noready memadr state", 32'(state_o), 32'd2);
        step(1'b0, LW, 1'b0);
        check("noready memrd state", 32'(state_o), 32'd3);
        step(1'b0, LW, 1'b0);
        check("noready memwb state", 32'(state_o), 32'd4);
        check("noready memwb ctrl", 32'(dut_word()), 32'(spec_word(4, 1'b0)));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
